// File: rtl/ext_mem_rr_merge.sv
// ext_mem_rr_merge: merges N native-bus masters onto one L2 slave bus with
// round-robin or fixed-priority arbitration, and sequences L2 invalidates.
//   state | meaning
//   IDLE  | no owner; start a pending invalidate or arbitrate
//   BUSY  | granted master drives the slave bus until s_ready
//   INV   | one-cycle force_inv_out strobe to L2
module ext_mem_rr_merge #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [N_MASTERS*(1+ADDR_W+DATA_W+DATA_W/8)-1:0] m_req,
  output logic [N_MASTERS*(DATA_W+1)-1:0]                 m_resp,
  output logic [ADDR_W+DATA_W+DATA_W/8:0]                 s_req,
  input  logic [DATA_W:0]                                 s_resp,
  input  logic                                            inv_req,
  input  logic                                            wtb_empty_in,
  output logic                                            force_inv_out,
  output logic [N_MASTERS-1:0]                            grant,
  output logic                                            busy
);
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W/8;
  localparam int RESP_W = DATA_W + 1;
  localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_INV} state_e;

  state_e               state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     own_q, own_d, last_q, last_d, win_idx;
  logic                 inv_pend_q, inv_pend_d;
  logic [N_MASTERS-1:0] m_valid;
  logic                 any_valid;
  logic                 s_ready;

  assign s_ready = s_resp[0];

  always_comb begin
    m_valid = '0;
    for (int i = 0; i < N_MASTERS; i++) m_valid[i] = m_req[i*REQ_W + REQ_W - 1];
  end
  assign any_valid = |m_valid;

  // Scan from the far end so the candidate closest to the start of the order wins.
  always_comb begin
    int j;
    j       = 0;
    win_idx = '0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      if (PRIO_MODE != 0) begin
        j = k - 1;
      end else begin
        j = int'(last_q) + k;
        if (j >= N_MASTERS) j = j - N_MASTERS;
      end
      if (m_valid[IDX_W'(j)]) win_idx = IDX_W'(j);
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    own_d      = own_q;
    last_d     = last_q;
    inv_pend_d = inv_pend_q;
    case (state_q)
      S_IDLE: begin
        if (inv_pend_q && wtb_empty_in) begin
          state_d = S_INV;
        end else if (any_valid) begin
          state_d = S_BUSY;
          own_d   = win_idx;
          for (int i = 0; i < N_MASTERS; i++) grant_d[i] = (win_idx == IDX_W'(i));
        end
      end
      S_BUSY: begin
        if (s_ready) begin
          state_d = S_IDLE;
          grant_d = '0;
          last_d  = own_q;
        end
      end
      S_INV: begin
        state_d    = S_IDLE;
        inv_pend_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    // A request landing in the INV cycle re-arms so it is not lost.
    if (inv_req) inv_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      own_q      <= '0;
      last_q     <= IDX_W'(N_MASTERS - 1);
      inv_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      own_q      <= own_d;
      last_q     <= last_d;
      inv_pend_q <= inv_pend_d;
    end
  end

  always_comb begin
    s_req  = '0;
    m_resp = '0;
    if (state_q == S_BUSY) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (own_q == IDX_W'(i)) begin
          s_req          = m_req[i*REQ_W +: REQ_W];
          s_req[REQ_W-1] = 1'b1;
          if (s_ready) m_resp[i*RESP_W +: RESP_W] = s_resp;
        end
      end
    end
  end

  assign force_inv_out = (state_q == S_INV);
  assign busy          = (state_q != S_IDLE);
  assign grant         = grant_q;

endmodule

// File: tb/tb_ext_mem_rr_merge.sv
// Randomized bench: a 3-master round-robin instance and a 2-master fixed-priority
// instance, each compared every cycle against a transaction-level reference.
module tb_ext_mem_rr_merge;
  localparam int RQ = 69;
  localparam int RS = 33;
  localparam int NR = 3;
  localparam int NF = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR*RQ-1:0] m_req_r;
  logic [NR*RS-1:0] m_resp_r;
  logic [RQ-1:0]    s_req_r;
  logic [RS-1:0]    s_resp_r;
  logic             inv_r, wtb_r, finv_r, busy_r;
  logic [NR-1:0]    grant_r;

  logic [NF*RQ-1:0] m_req_f;
  logic [NF*RS-1:0] m_resp_f;
  logic [RQ-1:0]    s_req_f;
  logic [RS-1:0]    s_resp_f;
  logic             inv_f, wtb_f, finv_f, busy_f;
  logic [NF-1:0]    grant_f;

  ext_mem_rr_merge #(.N_MASTERS(NR), .ADDR_W(32), .DATA_W(32), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .m_req(m_req_r), .m_resp(m_resp_r), .s_req(s_req_r),
    .s_resp(s_resp_r), .inv_req(inv_r), .wtb_empty_in(wtb_r),
    .force_inv_out(finv_r), .grant(grant_r), .busy(busy_r));

  ext_mem_rr_merge #(.N_MASTERS(NF), .ADDR_W(32), .DATA_W(32), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .m_req(m_req_f), .m_resp(m_resp_f), .s_req(s_req_f),
    .s_resp(s_resp_f), .inv_req(inv_f), .wtb_empty_in(wtb_f),
    .force_inv_out(finv_f), .grant(grant_f), .busy(busy_f));

  // Stimulus, indexed [instance][master]; instance 0 = round-robin, 1 = fixed.
  logic        v[2][3];
  logic [31:0] a[2][3];
  logic [31:0] wd[2][3];
  logic [3:0]  st[2][3];
  logic        rdy_seen[2][3];
  logic [31:0] l2_rdata[2];
  logic        l2_rdy[2];
  logic        wtb[2];
  logic        invq[2];

  // Reference: owner = master holding the bus (-1 none), inv_now = strobe cycle.
  int owner[2];
  int last[2];
  bit inv_now[2];
  bit pend[2];

  int n_cmp = 0;
  int n_err = 0;

  always_comb begin
    m_req_r = '0;
    m_req_f = '0;
    for (int i = 0; i < NR; i++) m_req_r[i*RQ +: RQ] = {v[0][i], a[0][i], wd[0][i], st[0][i]};
    for (int i = 0; i < NF; i++) m_req_f[i*RQ +: RQ] = {v[1][i], a[1][i], wd[1][i], st[1][i]};
  end
  assign s_resp_r = {l2_rdata[0], l2_rdy[0]};
  assign s_resp_f = {l2_rdata[1], l2_rdy[1]};
  assign inv_r    = invq[0];
  assign inv_f    = invq[1];
  assign wtb_r    = wtb[0];
  assign wtb_f    = wtb[1];

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int n_of(input int d);
    return (d == 0) ? NR : NF;
  endfunction

  function automatic int pick(input int d);
    int r, n, j;
    r = -1;
    n = n_of(d);
    if (d == 1) begin
      for (int k = 0; k < n; k++) if (r < 0 && v[d][k]) r = k;
    end else begin
      for (int k = 1; k <= n; k++) begin
        j = (last[d] + k) % n;
        if (r < 0 && v[d][j]) r = j;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      owner[d]   = -1;
      inv_now[d] = 1'b0;
      pend[d]    = 1'b0;
      last[d]    = n_of(d) - 1;
      for (int i = 0; i < 3; i++) rdy_seen[d][i] = 1'b0;
    end
  endtask

  task automatic drive();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < n_of(d); i++) begin
        if (v[d][i] && !rdy_seen[d][i]) begin
          v[d][i] = 1'b1;
        end else if ((v[d][i] && $urandom_range(2) != 0) || (!v[d][i] && $urandom_range(1) == 0)) begin
          v[d][i]  = 1'b1;
          a[d][i]  = $urandom;
          wd[d][i] = $urandom;
          st[d][i] = 4'($urandom);
        end else begin
          v[d][i] = 1'b0;
        end
        rdy_seen[d][i] = 1'b0;
      end
      l2_rdy[d]   = ($urandom_range(2) == 0);
      l2_rdata[d] = $urandom;
      if ($urandom_range(7) == 0) wtb[d] = ~wtb[d];
      invq[d] = ($urandom_range(9) == 0);
    end
  endtask

  task automatic check_step(input int d);
    logic [127:0] e_grant, e_sreq, e_mresp;
    int o;
    string p;
    o = owner[d];
    p = (d == 0) ? "rr" : "fp";
    e_grant = '0;
    e_sreq  = '0;
    e_mresp = '0;
    if (o >= 0) begin
      e_grant[o]        = 1'b1;
      e_sreq[RQ-1:0]    = {1'b1, a[d][o], wd[d][o], st[d][o]};
      if (l2_rdy[d]) begin
        e_mresp[o*RS +: RS] = {l2_rdata[d], 1'b1};
        rdy_seen[d][o]      = 1'b1;
      end
    end
    check_eq({p, ".grant"}, (d == 0) ? 128'(grant_r) : 128'(grant_f), e_grant);
    check_eq({p, ".busy"},  (d == 0) ? 128'(busy_r)  : 128'(busy_f),  128'((o >= 0) || inv_now[d]));
    check_eq({p, ".force_inv"}, (d == 0) ? 128'(finv_r) : 128'(finv_f), 128'(inv_now[d]));
    check_eq({p, ".s_req"},  (d == 0) ? 128'(s_req_r)  : 128'(s_req_f),  e_sreq);
    check_eq({p, ".m_resp"}, (d == 0) ? 128'(m_resp_r) : 128'(m_resp_f), e_mresp);
    if (rst) begin
      if (inv_now[d]) begin
        inv_now[d] = 1'b0;
        pend[d]    = 1'b0;
      end else if (o >= 0) begin
        if (l2_rdy[d]) begin
          last[d]  = o;
          owner[d] = -1;
        end
      end else if (pend[d] && wtb[d]) begin
        inv_now[d] = 1'b1;
      end else begin
        owner[d] = pick(d);
      end
      if (invq[d]) pend[d] = 1'b1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    check_step(0);
    check_step(1);
  endtask

  initial begin
    bit found;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 3; i++) begin
        v[d][i] = 1'b0; a[d][i] = '0; wd[d][i] = '0; st[d][i] = '0;
      end
      l2_rdata[d] = '0; l2_rdy[d] = 1'b0; wtb[d] = 1'b1; invq[d] = 1'b0;
    end
    model_reset();

    #2 rst = 1'b0;
    #1;
    check_eq("reset.grant",  128'(grant_r),  '0);
    check_eq("reset.busy",   128'(busy_r),   '0);
    check_eq("reset.s_req",  128'(s_req_r),  '0);
    check_eq("reset.m_resp", 128'(m_resp_r), '0);
    check_eq("reset.force",  128'(finv_r),   '0);
    check_eq("reset.fp_grant", 128'(grant_f), '0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    repeat (4000) cycle();

    // Abandon an in-flight transfer with an asynchronous reset.
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      cycle();
      if (owner[0] >= 0) found = 1'b1;
    end
    check_eq("rst.found_busy", 128'(found), 128'(1));
    @(posedge clk);
    #1;
    check_eq("rst.pre_busy", 128'(busy_r), 128'(found));
    #1 rst = 1'b0;
    #1;
    check_eq("rst.s_valid", 128'(s_req_r[RQ-1]), '0);
    check_eq("rst.grant",   128'(grant_r), '0);
    check_eq("rst.busy",    128'(busy_r),  '0);
    model_reset();
    cycle();
    @(posedge clk);
    #1 rst = 1'b1;

    repeat (1000) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ext_mem_rr_merge.md
Name: ext_mem_rr_merge

Overview:
- Parametrised successor to the fixed 1/2-master merge in front of the L2 cache.
- Merges N_MASTERS native-bus masters (L1 back-ends or raw I/D buses) into one native slave bus.
- Arbitration is round-robin or fixed priority.
- Owns L2 invalidate sequencing: an invalidate request is held pending and issued only when the slave bus is idle and the write-through buffer is empty.

Parameters:
- N_MASTERS, 2: number of masters, 1..8.
- ADDR_W, 32: word-address width on the master and slave buses.
- DATA_W, 32: data width; wstrb width is DATA_W/8.
- PRIO_MODE, 0: 0 = round-robin; 1 = fixed priority, lowest index wins.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- m_req  in  N_MASTERS*(1+ADDR_W+DATA_W+DATA_W/8)  packed per master {valid, addr, wdata, wstrb}; master 0 in the LSBs.
- m_resp  out  N_MASTERS*(DATA_W+1)  packed per master {rdata, ready}; master 0 in the LSBs.
- s_req  out  1+ADDR_W+DATA_W+DATA_W/8  {valid, addr, wdata, wstrb} to L2.
- s_resp  in  DATA_W+1  {rdata, ready} from L2.
- inv_req  in  1  invalidate request pulse (from L1 force_inv_out).
- wtb_empty_in  in  1  L2 write-through buffer empty.
- force_inv_out  out  1  one-cycle invalidate strobe to L2.
- grant  out  N_MASTERS  one-hot current owner; 0 when idle.
- busy  out  1  a transaction is in flight.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - state=IDLE, grant=0, busy=0, s_req=0, all m_resp=0, force_inv_out=0.
  - inv_pending=0; last_grant=N_MASTERS-1, so master 0 wins first under round-robin.
- FSM states: IDLE, BUSY, INV.
- IDLE:
  - If inv_pending=1 and wtb_empty_in=1, go to INV. Invalidate has priority over new requests.
  - Else if any master valid, pick the winner, register grant, go to BUSY.
  - Round-robin winner: first valid index scanning last_grant+1, last_grant+2, ... modulo N_MASTERS.
  - Fixed-priority winner: lowest valid index.
  - Else stay in IDLE.
- BUSY:
  - s_req = granted master's fields, with s_valid=1.
  - On s_ready=1: route s_rdata and ready=1 to the granted master for that same cycle only; set last_grant=winner; grant=0; go to IDLE.
  - Non-granted masters always see ready=0 and rdata=0.
  - Arbitration adds exactly 1 cycle: the request is seen in IDLE and s_valid rises the next cycle. Back-to-back requests from any masters therefore cost one IDLE cycle each.
  - The grant is held until s_ready even if the master drops valid. Masters must hold valid and fields stable until ready; violation is undefined.
- INV:
  - force_inv_out=1 for exactly one cycle; clear inv_pending; go to IDLE.
  - s_valid is 0 in INV, so an invalidate never overlaps a request.
- inv_pending:
  - Set on inv_req=1 in any state.
  - inv_req arriving in the same cycle the INV state clears it re-sets it, so the request is not lost; a second invalidate follows.
  - Multiple inv_req pulses while pending collapse into one invalidate.
- wtb_empty_in=0 while pending:
  - Invalidate is deferred; requests continue to be granted in IDLE.
  - The pending check repeats every IDLE cycle.
- busy=1 in BUSY and INV.
- s_req is 0 whenever the state is not BUSY.
- N_MASTERS=1:
  - No arbitration logic; grant is 1 in BUSY.
  - The 1-cycle latency is kept for uniform timing.
- Reset asserted mid-transaction: the transaction is abandoned, s_valid drops asynchronously, inv_pending is lost. L2 must be reset by the same rst.

Test Plan:
- Single master: N_MASTERS=2, master 0 read at addr 0x40. L2 returns 0xDEADBEEF with ready 3 cycles after s_valid.
  - s_valid rises 1 cycle after m_valid.
  - Master 0 gets ready=1 and rdata=0xDEADBEEF.
  - grant=01 during BUSY.
  - Master 1 sees ready=0 throughout.
- Round-robin: masters 0 and 1 hold valid continuously, L2 ready every access.
  - Grant order 0,1,0,1.
  - Each grant is separated by one IDLE cycle.
- Fixed priority: PRIO_MODE=1, masters 0 and 1 continuously valid.
  - Master 0 is granted every time; master 1 is starved.
- Invalidate during BUSY: inv_req pulsed while BUSY, wtb_empty_in=1.
  - No force_inv_out until after s_ready.
  - force_inv_out is high for exactly 1 cycle in the cycle after return to IDLE.
  - A waiting request is granted only after INV.
- Invalidate deferral: inv_req pulsed with wtb_empty_in=0 for 10 cycles, requests flowing.
  - Requests are still granted.
  - force_inv_out fires the first IDLE cycle after wtb_empty_in=1.
  - Three inv_req pulses while pending yield one strobe.
- Reset mid-transaction: rst=0 while BUSY.
  - s_valid, grant and busy drop to 0 immediately, without waiting for a clock edge.
  - After release, master 0 wins first.
